// File: rtl/bus_target_if.sv
// Bus-side signal bundle for bus_target; D and ACK are shared tri-state
// nets and stay outside the bundle as plain wires.
interface bus_target_if;
   logic [15:0] A;
   logic [2:0]  MASTER;
   logic [2:0]  DEST;
   logic [11:0] SIZE;
   logic        RW;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        busy;
   logic        err;

   modport master (
      output A, MASTER, DEST, SIZE, RW,
      output mem_rdata, mem_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  busy, err
   );

   modport slave (
      input  A, MASTER, DEST, SIZE, RW,
      input  mem_rdata, mem_ready,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output busy, err
   );
endinterface

// File: rtl/bus_target.sv
// Shared-bus burst target bridging to a local memory port.
// Optional access timeout enabled by BUS_TARGET_TIMEOUT_EN.
module bus_target #(
   parameter logic [2:0] MY_ID = 3'd1
) (
   input  logic        BUS_CLK,
   input  logic        RST,
   inout  wire  [31:0] D,
   input  logic [15:0] A,
   input  logic [2:0]  MASTER,
   input  logic [2:0]  DEST,
   input  logic [11:0] SIZE,
   input  logic        RW,
   inout  wire         ACK,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_ACKB,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_addr;
   logic [11:0] r_cnt;
   logic        r_rw;
   logic [2:0]  r_mst;
   logic [31:0] r_rdata;

   logic w_sel;
   logic w_latch;
   logic w_cap;
   logic w_step;
   logic w_tmo_hit;
   logic w_unused_mst;

   assign w_sel        = (DEST == MY_ID);
   assign w_unused_mst = ^r_mst;

`ifdef BUS_TARGET_TIMEOUT_EN
   logic [3:0] r_tmo;
   logic       r_err;

   // Fifteenth stalled ACCESS cycle gives up on the beat
   assign w_tmo_hit = (r_state == S_ACCESS) && w_sel &&
                      !mem_ready && (r_tmo == 4'd14);

   always_ff @(posedge BUS_CLK) begin
      if (RST) begin
         r_tmo <= 4'd0;
         r_err <= 1'b0;
      end else begin
         r_err <= w_tmo_hit;
         if (w_next == S_ACCESS && r_state != S_ACCESS)
            r_tmo <= 4'd0;
         else if (r_state == S_ACCESS && !mem_ready)
            r_tmo <= r_tmo + 4'd1;
      end
   end

   assign err = r_err;
`else
   assign w_tmo_hit = 1'b0;
   assign err       = 1'b0;
`endif

   always_comb begin
      w_next  = r_state;
      w_latch = 1'b0;
      w_cap   = 1'b0;
      w_step  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_sel) begin
               if (SIZE != 12'd0) begin
                  w_latch = 1'b1;
                  w_next  = S_ACCESS;
               end else begin
                  w_next  = S_DONE;
               end
            end
         end
         S_ACCESS: begin
            if (!w_sel) begin
               w_next = S_IDLE;
            end else if (mem_ready) begin
               w_cap  = !r_rw;
               w_next = S_ACKB;
            end else if (w_tmo_hit) begin
               w_next = S_DONE;
            end
         end
         S_ACKB: begin
            w_step = 1'b1;
            if (!w_sel)
               w_next = S_IDLE;
            else if (r_cnt == 12'd1)
               w_next = S_DONE;
            else
               w_next = S_ACCESS;
         end
         S_DONE: begin
            // Held selection parks here so it cannot start a new burst
            if (!w_sel)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_addr  <= 16'd0;
         r_cnt   <= 12'd0;
         r_rw    <= 1'b0;
         r_mst   <= 3'd0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_addr <= A;
            r_cnt  <= SIZE;
            r_rw   <= RW;
            r_mst  <= MASTER;
         end
         if (w_cap)
            r_rdata <= mem_rdata;
         if (w_step) begin
            r_addr <= r_addr + 16'd1;
            r_cnt  <= r_cnt - 12'd1;
         end
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign mem_req   = (r_state == S_ACCESS);
   assign mem_we    = mem_req & r_rw;
   assign mem_addr  = r_addr;
   assign mem_wdata = D;

   assign ACK = (r_state == S_IDLE) ? 1'bz : (r_state == S_ACKB);
   assign D   = (r_state == S_ACKB && !r_rw) ? r_rdata : 32'bz;

endmodule

// File: tb/tb_bus_target.sv
// Randomised transaction-trace bench for bus_target; each transfer is
// expanded into an expected per-cycle trace from the protocol rules.
module tb_bus_target;

   localparam logic [2:0] ID = 3'd1;

   typedef struct packed {
      logic        rst;
      logic [2:0]  dest;
      logic        sel;
      logic [15:0] a;
      logic [11:0] sz;
      logic        rw;
      logic        rdy;
      logic        den;
      logic [31:0] wd;
      logic        busy;
      logic        req;
      logic        we;
      logic        achk;
      logic [15:0] addr;
      logic        ack;
      logic        dchk;
      logic [31:0] d;
      logic        err;
   } cyc_t;

   typedef logic [84:0] vec_t;

   logic        clk;
   logic        rst;
   logic        tb_den;
   logic [31:0] tb_d;
   logic [15:0] salt;
   tri0  [31:0] D;
   tri0         ACK;

   int          n_vec;
   int          n_err;
   cyc_t        exp_q[$];
   int          waits_g[16];
   logic [31:0] wdat_g[16];

   bus_target_if intf();

   assign D = tb_den ? tb_d : 32'bz;
   assign intf.mem_rdata = {salt, intf.mem_addr};

   bus_target #(.MY_ID(ID)) dut (
      .BUS_CLK   (clk),
      .RST       (rst),
      .D         (D),
      .A         (intf.A),
      .MASTER    (intf.MASTER),
      .DEST      (intf.DEST),
      .SIZE      (intf.SIZE),
      .RW        (intf.RW),
      .ACK       (ACK),
      .mem_req   (intf.mem_req),
      .mem_we    (intf.mem_we),
      .mem_addr  (intf.mem_addr),
      .mem_wdata (intf.mem_wdata),
      .mem_rdata (intf.mem_rdata),
      .mem_ready (intf.mem_ready),
      .busy      (intf.busy),
      .err       (intf.err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t expv(input cyc_t c);
      return {c.busy, c.req, c.we, c.addr, c.ack, c.d, c.err,
              (c.req & c.we) ? c.wd : 32'h0};
   endfunction

   task automatic apply(input cyc_t c, output vec_t o);
      rst       = c.rst;
      intf.DEST = c.dest;
      if (c.sel) begin
         intf.A    = c.a;
         intf.SIZE = c.sz;
         intf.RW   = c.rw;
      end else begin
         intf.A    = 16'($urandom);
         intf.SIZE = 12'($urandom);
         intf.RW   = 1'($urandom);
      end
      intf.MASTER    = 3'($urandom);
      intf.mem_ready = c.rdy;
      tb_den         = c.den;
      tb_d           = c.wd;
      #4;
      o = {intf.busy, intf.mem_req, intf.mem_we,
           c.achk ? intf.mem_addr : 16'h0, ACK,
           c.dchk ? D : 32'h0, intf.err,
           (c.req & c.we) ? intf.mem_wdata : 32'h0};
      @(posedge clk);
      #1;
   endtask

   function automatic void clr_waits();
      for (int i = 0; i < 16; i++) begin
         waits_g[i] = 0;
         wdat_g[i]  = 32'($urandom);
      end
   endfunction

   function automatic void push_sel(input logic rw, input logic [15:0] a,
                                    input logic [11:0] sz);
      cyc_t c = '0;
      c.dest = ID;
      c.sel  = 1'b1;
      c.a    = a;
      c.sz   = sz;
      c.rw   = rw;
      exp_q.push_back(c);
   endfunction

   function automatic void push_acc(input logic rw, input logic [15:0] ad,
                                    input logic rdy, input logic [31:0] wd);
      cyc_t c = '0;
      c.dest = ID;
      c.rdy  = rdy;
      c.den  = rw;
      c.wd   = wd;
      c.busy = 1'b1;
      c.req  = 1'b1;
      c.we   = rw;
      c.achk = 1'b1;
      c.addr = ad;
      exp_q.push_back(c);
   endfunction

   function automatic void push_ack(input logic rw, input logic [15:0] ad,
                                    input logic [31:0] wd);
      cyc_t c = '0;
      c.dest = ID;
      c.den  = rw;
      c.wd   = wd;
      c.busy = 1'b1;
      c.ack  = 1'b1;
      c.dchk = !rw;
      c.d    = rw ? 32'h0 : {salt, ad};
      exp_q.push_back(c);
   endfunction

   // Selection cycle plus nshow beats of a sz-beat burst
   function automatic void push_xfer(input logic rw, input logic [15:0] a,
                                     input logic [11:0] sz, input int nshow);
      logic [15:0] ad;
      push_sel(rw, a, sz);
      for (int i = 0; i < nshow; i++) begin
         ad = a + 16'(i);
         for (int w = 0; w < waits_g[i]; w++)
            push_acc(rw, ad, 1'b0, wdat_g[i]);
         push_acc(rw, ad, 1'b1, wdat_g[i]);
         push_ack(rw, ad, wdat_g[i]);
      end
   endfunction

   function automatic void push_done(input int hold);
      cyc_t c = '0;
      c.dest = ID;
      c.busy = 1'b1;
      c.dchk = 1'b0;
      for (int i = 0; i <= hold; i++)
         exp_q.push_back(c);
      c.dest = 3'd0;
      exp_q.push_back(c);
   endfunction

   function automatic void push_idle(input int n);
      cyc_t c = '0;
      for (int i = 0; i < n; i++)
         exp_q.push_back(c);
   endfunction

   task automatic test_reset();
      cyc_t c;
      vec_t o;
      c      = '0;
      c.rst  = 1'b1;
      c.achk = 1'b1;
      apply(c, o);
      apply(c, o);
      for (int i = 0; i < 2; i++) begin
         apply(c, o);
         n_vec++;
         if (o !== expv(c)) begin
            n_err++;
            $display("FAIL reset cyc%0d got %h want %h", i, o, expv(c));
         end
      end
   endtask

   task automatic test_write();
      cyc_t c;
      vec_t o;
      int   k = 0;
      clr_waits();
      wdat_g[0] = 32'hA5A5_0001;
      wdat_g[1] = 32'hA5A5_0002;
      push_xfer(1'b1, 16'h0010, 12'd2, 2);
      push_done(2);
      push_idle(1);
      while (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         apply(c, o);
         n_vec++;
         if (o !== expv(c)) begin
            n_err++;
            $display("FAIL write cyc%0d got %h want %h", k, o, expv(c));
         end
         k++;
      end
   endtask

   task automatic test_read_wrap();
      cyc_t c;
      vec_t o;
      int   k = 0;
      clr_waits();
      salt = 16'h0000;
      push_xfer(1'b0, 16'hFFFF, 12'd2, 2);
      push_done(0);
      push_idle(1);
      while (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         apply(c, o);
         n_vec++;
         if (o !== expv(c)) begin
            n_err++;
            $display("FAIL read_wrap cyc%0d got %h want %h", k, o, expv(c));
         end
         k++;
      end
   endtask

   task automatic test_wait_states();
      cyc_t c;
      vec_t o;
      int   k = 0;
      clr_waits();
      salt       = 16'h3C3C;
      waits_g[0] = 3;
      push_xfer(1'b0, 16'h0400, 12'd1, 1);
      push_done(0);
      push_idle(1);
      while (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         apply(c, o);
         n_vec++;
         if (o !== expv(c)) begin
            n_err++;
            $display("FAIL wait cyc%0d got %h want %h", k, o, expv(c));
         end
         k++;
      end
   endtask

   task automatic test_abort();
      cyc_t c;
      vec_t o;
      int   k = 0;
      clr_waits();
      push_xfer(1'b1, 16'h2000, 12'd4, 1);
      push_acc(1'b1, 16'h2001, 1'b1, wdat_g[1]);
      exp_q[exp_q.size()-1].dest = 3'd0;
      push_idle(3);
      while (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         apply(c, o);
         n_vec++;
         if (o !== expv(c)) begin
            n_err++;
            $display("FAIL abort cyc%0d got %h want %h", k, o, expv(c));
         end
         k++;
      end
   endtask

   task automatic test_reset_mid_and_size0();
      cyc_t c;
      vec_t o;
      int   k = 0;
      clr_waits();
      salt = 16'h00AA;
      push_xfer(1'b0, 16'h1234, 12'd3, 1);
      exp_q[exp_q.size()-1].rst = 1'b1;
      push_idle(2);
      exp_q[exp_q.size()-2].achk = 1'b1;
      push_sel(1'b0, 16'h5555, 12'd0);
      push_done(2);
      push_idle(1);
      while (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         apply(c, o);
         n_vec++;
         if (o !== expv(c)) begin
            n_err++;
            $display("FAIL rst_size0 cyc%0d got %h want %h", k, o, expv(c));
         end
         k++;
      end
   endtask

   task automatic test_timeout();
      cyc_t c;
      vec_t o;
      int   k = 0;
      clr_waits();
      push_sel(1'b0, 16'h0777, 12'd2);
`ifdef BUS_TARGET_TIMEOUT_EN
      for (int i = 0; i < 15; i++)
         push_acc(1'b0, 16'h0777, 1'b0, 32'h0);
      c      = '0;
      c.dest = ID;
      c.busy = 1'b1;
      c.err  = 1'b1;
      exp_q.push_back(c);
      push_done(0);
      push_idle(1);
`else
      for (int i = 0; i < 25; i++)
         push_acc(1'b0, 16'h0777, 1'b0, 32'h0);
      push_acc(1'b0, 16'h0777, 1'b0, 32'h0);
      exp_q[exp_q.size()-1].dest = 3'd0;
      push_idle(2);
`endif
      while (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         apply(c, o);
         n_vec++;
         if (o !== expv(c)) begin
            n_err++;
            $display("FAIL timeout cyc%0d got %h want %h", k, o, expv(c));
         end
         k++;
      end
   endtask

   task automatic test_back_to_back();
      cyc_t        c;
      vec_t        o;
      int          k = 0;
      int          n;
      logic        rw;
      logic [15:0] a;
      salt = 16'($urandom);
      for (int t = 0; t < 16; t++) begin
         clr_waits();
         rw = 1'($urandom);
         n  = $urandom_range(1, 5);
         if ($urandom_range(0, 3) == 0)
            a = 16'hFFFF - 16'($urandom_range(0, 3));
         else
            a = 16'($urandom);
         for (int i = 0; i < n; i++)
            waits_g[i] = $urandom_range(0, 3);
         push_xfer(rw, a, 12'(n), n);
         push_done($urandom_range(0, 2));
         push_idle($urandom_range(0, 1));
      end
      while (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         apply(c, o);
         n_vec++;
         if (o !== expv(c)) begin
            n_err++;
            $display("FAIL b2b cyc%0d got %h want %h", k, o, expv(c));
         end
         k++;
      end
   endtask

   initial begin
      n_vec          = 0;
      n_err          = 0;
      rst            = 1'b1;
      tb_den         = 1'b0;
      tb_d           = 32'h0;
      salt           = 16'h0;
      intf.A         = 16'h0;
      intf.MASTER    = 3'd0;
      intf.DEST      = 3'd0;
      intf.SIZE      = 12'd0;
      intf.RW        = 1'b0;
      intf.mem_ready = 1'b0;
      test_reset();
      test_write();
      test_read_wrap();
      test_wait_states();
      test_abort();
      test_reset_mid_and_size0();
      test_timeout();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
